// File: rtl/shifter_arbiter.sv
// shifter_arbiter: round-robin sharing of one barrel shifter between
// the ALU operand-2 path (0) and the LSU address-offset path (1).
module shifter_arbiter #(
  parameter int WIDTH   = 32,
  parameter int AMT_W   = 6,
  parameter int RR_INIT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_in,
  input  logic [5:0]         req_op,
  input  logic [2*AMT_W-1:0] req_amt,
  input  logic [1:0]         req_cin,
  output logic [WIDTH-1:0]   sh_in,
  output logic [2:0]         sh_op,
  output logic [AMT_W-1:0]   sh_amt,
  output logic               sh_cin,
  input  logic [WIDTH-1:0]   sh_out,
  input  logic               sh_cout,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic [1:0]         rsp_cout,
  output logic               busy
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_st_t;

  buf_st_t    st_q [2];
  logic       ptr_q;
  logic       sel;
  logic [1:0] elig;
  logic [1:0] gnt;

  // a full buffer that is draining this cycle can take a new result
  assign elig = req_valid & (~rsp_valid | rsp_ready);

  always_comb begin
    gnt = 2'b00;
    sel = ptr_q;
    unique case (elig)
      2'b11: begin
        sel = ptr_q;
        gnt = ptr_q ? 2'b10 : 2'b01;
      end
      2'b01: begin
        sel = 1'b0;
        gnt = 2'b01;
      end
      2'b10: begin
        sel = 1'b1;
        gnt = 2'b10;
      end
      default: begin
        sel = ptr_q;
        gnt = 2'b00;
      end
    endcase
  end

  assign req_ready = gnt;

  assign sh_in  = sel ? req_in[2*WIDTH-1:WIDTH]
                      : req_in[WIDTH-1:0];
  assign sh_op  = sel ? req_op[5:3] : req_op[2:0];
  assign sh_amt = sel ? req_amt[2*AMT_W-1:AMT_W]
                      : req_amt[AMT_W-1:0];
  assign sh_cin = sel ? req_cin[1] : req_cin[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'(RR_INIT);
    end else if (|gnt) begin
      ptr_q <= ~sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i] <= EMPTY;
      end
      rsp_data <= '0;
      rsp_cout <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (gnt[i]) begin
          rsp_data[i*WIDTH +: WIDTH] <= sh_out;
          rsp_cout[i]                <= sh_cout;
        end
        unique case (st_q[i])
          EMPTY: begin
            if (gnt[i]) st_q[i] <= FULL;
          end
          FULL: begin
            if (rsp_ready[i] && !gnt[i]) st_q[i] <= EMPTY;
          end
          default: st_q[i] <= EMPTY;
        endcase
      end
    end
  end

  always_comb begin
    rsp_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      rsp_valid[i] = (st_q[i] == FULL);
    end
  end

  assign busy = |rsp_valid;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed scoreboard bench for shifter_arbiter with a
// behavioural barrel shifter closing the sh_* loop.
module tb_shifter_arbiter;

  localparam int W = 32;
  localparam int A = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [2*W-1:0] req_in;
  logic [5:0]   req_op;
  logic [2*A-1:0] req_amt;
  logic [1:0]   req_cin;
  logic [W-1:0] sh_in;
  logic [2:0]   sh_op;
  logic [A-1:0] sh_amt;
  logic         sh_cin;
  logic [W-1:0] sh_out;
  logic         sh_cout;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [2*W-1:0] rsp_data;
  logic [1:0]   rsp_cout;
  logic         busy;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [W-1:0] data;
    logic         cout;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  shifter_arbiter #(.WIDTH(W), .AMT_W(A), .RR_INIT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in(req_in), .req_op(req_op),
    .req_amt(req_amt), .req_cin(req_cin),
    .sh_in(sh_in), .sh_op(sh_op),
    .sh_amt(sh_amt), .sh_cin(sh_cin),
    .sh_out(sh_out), .sh_cout(sh_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // behavioural shifter: LSL/LSR/ASR/ROR, RRX on op 110 amt 0
  always_comb begin
    logic [63:0] t;
    int n;
    n = int'(sh_amt);
    t = '0;
    sh_out = sh_in;
    sh_cout = sh_cin;
    if (n == 0) begin
      if (sh_op == 3'b110) begin
        sh_out = {sh_cin, sh_in[W-1:1]};
        sh_cout = sh_in[0];
      end
    end else if (n <= 32) begin
      case (sh_op[2:1])
        2'b00: begin
          t = {32'b0, sh_in} << n;
          sh_out = t[31:0];
          sh_cout = t[32];
        end
        2'b01: begin
          t = {sh_in, 32'b0} >> n;
          sh_out = t[63:32];
          sh_cout = t[31];
        end
        2'b10: begin
          t = $signed({sh_in, 32'b0}) >>> n;
          sh_out = t[63:32];
          sh_cout = t[31];
        end
        default: begin
          t = {sh_in, sh_in} >> (n % 32);
          sh_out = t[31:0];
          sh_cout = t[31];
        end
      endcase
    end else begin
      sh_out = '0;
      sh_cout = 1'b0;
    end
  end

  task automatic chk(string name, logic [63:0] got,
                     logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // monitor: compare every presented response, pop on handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid[0]) begin
        if (q0.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp0_unexpected: got=%0h exp=none",
                   rsp_data[W-1:0]);
        end else begin
          chk("rsp0_data", 64'(rsp_data[W-1:0]), 64'(q0[0].data));
          chk("rsp0_cout", 64'(rsp_cout[0]), 64'(q0[0].cout));
          if (rsp_ready[0]) void'(q0.pop_front());
        end
      end
      if (rsp_valid[1]) begin
        if (q1.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp1_unexpected: got=%0h exp=none",
                   rsp_data[2*W-1:W]);
        end else begin
          chk("rsp1_data", 64'(rsp_data[2*W-1:W]), 64'(q1[0].data));
          chk("rsp1_cout", 64'(rsp_cout[1]), 64'(q1[0].cout));
          if (rsp_ready[1]) void'(q1.pop_front());
        end
      end
    end
  end

  task automatic set_req(int i, logic [W-1:0] v, logic [2:0] op,
                         logic [A-1:0] amt, logic c);
    req_in[i*W +: W] = v;
    req_op[i*3 +: 3] = op;
    req_amt[i*A +: A] = amt;
    req_cin[i] = c;
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rdy(string name, logic [1:0] exp);
    @(negedge clk);
    chk(name, 64'(req_ready), 64'(exp));
  endtask

  task automatic push(int i, logic [W-1:0] d, logic c);
    exp_t e;
    e.data = d;
    e.cout = c;
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_in = '0;
    req_op = '0;
    req_amt = '0;
    req_cin = '0;
    rsp_ready = 2'b11;
    #12;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_rsp_cout", 64'(rsp_cout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single request, ptr 0 -> 1
    go();
    set_req(0, 32'h0000_00F1, 3'b000, 6'd4, 1'b0);
    req_valid = 2'b01;
    chk_rdy("single_rdy", 2'b01);
    push(0, 32'h0000_0F10, 1'b0);

    // ptr at 1: req1 wins contention
    go();
    set_req(0, 32'h0000_0001, 3'b000, 6'd1, 1'b0);
    set_req(1, 32'h0000_00F0, 3'b010, 6'd4, 1'b0);
    req_valid = 2'b11;
    chk_rdy("ptr1_rdy", 2'b10);
    push(1, 32'h0000_000F, 1'b0);

    go();
    req_valid = 2'b01;
    chk_rdy("ptr0_only_rdy", 2'b01);
    push(0, 32'h0000_0002, 1'b0);

    // lone req1 wins with ptr at 1 -> ptr 0
    go();
    set_req(1, 32'h00FF_0000, 3'b001, 6'd8, 1'b0);
    req_valid = 2'b10;
    chk_rdy("lone1_rdy", 2'b10);
    push(1, 32'hFF00_0000, 1'b0);

    // contention, ptr 0
    go();
    set_req(0, 32'h8000_0000, 3'b100, 6'd4, 1'b0);
    set_req(1, 32'h1234_5678, 3'b011, 6'd0, 1'b1);
    req_valid = 2'b11;
    chk_rdy("cont_c1_rdy", 2'b01);
    push(0, 32'hF800_0000, 1'b0);

    go();
    chk_rdy("cont_c2_rdy", 2'b10);
    push(1, 32'h1234_5678, 1'b1);

    // back-pressure on buffer 1
    go();
    rsp_ready = 2'b01;
    set_req(0, 32'h0000_0011, 3'b000, 6'd0, 1'b0);
    set_req(1, 32'h0000_DEAD, 3'b000, 6'd0, 1'b0);
    req_valid = 2'b11;
    chk_rdy("bp_c1_rdy", 2'b01);
    push(0, 32'h0000_0011, 1'b0);

    go();
    set_req(0, 32'h0000_0022, 3'b000, 6'd0, 1'b0);
    chk_rdy("bp_c2_rdy", 2'b01);
    chk("bp_hold_data", 64'(rsp_data[2*W-1:W]), 64'h1234_5678);
    push(0, 32'h0000_0022, 1'b0);

    // buffer 1 drains and refills in one cycle
    go();
    rsp_ready = 2'b11;
    chk_rdy("bp_release_rdy", 2'b10);
    push(1, 32'h0000_DEAD, 1'b0);

    go();
    set_req(0, 32'h0000_0033, 3'b000, 6'd0, 1'b0);
    req_valid = 2'b01;
    chk_rdy("fill0_rdy", 2'b01);
    push(0, 32'h0000_0033, 1'b0);

    // buffer 0 drains and refills in one cycle
    go();
    set_req(0, 32'h0000_00AB, 3'b111, 6'd8, 1'b0);
    chk_rdy("refill0_rdy", 2'b01);
    chk("refill0_valid_pre", 64'(rsp_valid[0]), 64'd1);
    push(0, 32'hAB00_0000, 1'b1);

    go();
    req_valid = 2'b00;
    @(negedge clk);
    chk("refill0_valid_post", 64'(rsp_valid[0]), 64'd1);

    go();
    @(negedge clk);
    chk("idle_valid", 64'(rsp_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // fill both buffers, then reset mid-stream (ptr at 1)
    go();
    rsp_ready = 2'b00;
    set_req(0, 32'h0000_0044, 3'b000, 6'd0, 1'b1);
    set_req(1, 32'h0000_0055, 3'b000, 6'd0, 1'b0);
    req_valid = 2'b11;
    chk_rdy("fill_c1_rdy", 2'b10);
    push(1, 32'h0000_0055, 1'b0);

    go();
    chk_rdy("fill_c2_rdy", 2'b01);
    push(0, 32'h0000_0044, 1'b1);

    go();
    chk_rdy("full_stall_rdy", 2'b00);
    chk("full_valid", 64'(rsp_valid), 64'd3);
    chk("full_busy", 64'(busy), 64'd1);

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_data", rsp_data, 64'd0);
    q0.delete();
    q1.delete();

    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    #1;
    chk("post_rst_rdy", 64'(req_ready), 64'd1);
    push(0, 32'h0000_0044, 1'b1);

    go();
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shifter_arbiter.md
Name: shifter_arbiter

Overview:
- Shares the single combinational barrel shifter between two requesters: requester 0 is the ALU operand-2 path and requester 1 is the load/store address-offset path.
- Round-robin arbitration with a valid/ready handshake on each request port.
- Drives the shared shifter inputs from the granted request, captures the shifter result and carry-out into a one-entry response buffer per requester, and returns it with its own valid/ready handshake.

Parameters:
- WIDTH, 32, data width of shifter operand and result.
- AMT_W, 6, shift-amount width; equals the shifter amount port width.
- RR_INIT, 0, requester index holding priority after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- req_ready  output  2  per-requester request accepted this cycle.
- req_in  input  2*WIDTH  operands; requester i uses bits [i*WIDTH +: WIDTH].
- req_op  input  6  3-bit shift op per requester, same encoding as the shifter (000 LSL imm … 111 ROR reg).
- req_amt  input  2*AMT_W  shift amount per requester.
- req_cin  input  2  carry flag in, per requester.
- sh_in  output  WIDTH  to shared shifter, operand.
- sh_op  output  3  to shared shifter, op.
- sh_amt  output  AMT_W  to shared shifter, amount.
- sh_cin  output  1  to shared shifter, carry in.
- sh_out  input  WIDTH  from shared shifter, result (combinational).
- sh_cout  input  1  from shared shifter, carry out.
- rsp_valid  output  2  response buffer i holds a result.
- rsp_ready  input  2  requester i consumes its response.
- rsp_data  output  2*WIDTH  buffered result per requester.
- rsp_cout  output  2  buffered carry-out per requester.
- busy  output  1  high when any response buffer is full.

Behaviour:
- Reset (rst_n low, async): rsp_valid=0, rsp_data=0, rsp_cout=0, priority pointer=RR_INIT, busy=0. req_ready is combinational and evaluates to 0 while nothing is eligible.
- Eligibility: requester i is eligible when req_valid[i]=1 and (rsp_valid[i]=0 or rsp_ready[i]=1). Buffer drain and refill may happen in the same cycle.
- Grant: at most one grant per cycle, combinational. If both requesters are eligible, the one at the priority pointer wins. If only one is eligible, it wins regardless of the pointer. req_ready[i] is high only for the winner.
- Pointer: on a grant to requester i, the pointer moves to 1-i at the clock edge. With no grant, the pointer holds.
- Shifter drive: sh_in, sh_op, sh_amt and sh_cin are muxed from the winner. With no grant they are driven from requester at the pointer, and the value is don't-care.
- Capture: on the edge where req_valid[i] and req_ready[i] are both high, rsp_data[i]<=sh_out, rsp_cout[i]<=sh_cout, rsp_valid[i]<=1. Latency is 1 cycle (accept in cycle N, rsp_valid in N+1).
- Drain: rsp_valid[i] clears on rsp_valid[i] and rsp_ready[i] with no new capture for i in that cycle. Simultaneous drain and capture loads the new data and leaves valid at 1.
- Data hold: rsp_data and rsp_cout stay stable while rsp_valid is high and rsp_ready is low.
- Per-buffer state machine, two states: EMPTY to FULL on capture; FULL to EMPTY on drain without capture; FULL to FULL on capture or stall.
- busy = |rsp_valid, registered through the rsp_valid flops.
- No back-pressure leaks across requesters: a full, stalled buffer on requester 1 never blocks requester 0.
- Reset mid-operation: pending responses are discarded and requesters must re-issue. The requester may drop req_valid without being accepted; there is no obligation to hold.
- Arithmetic: the block does not modify data. The carry passed to the shifter is the requester's own req_cin, including RRX (op 110, amt 0).

Test Plan:
- Single request: req0 valid, op 000, amt 4, in 0x0000_00F1, cin 0. Expect req_ready[0]=1 in the same cycle; next cycle rsp_valid[0]=1, rsp_data 0x0000_0F10, rsp_cout 0; pointer moves to 1.
- Contention with pointer=0, both valid. Req0 is op 100, amt 4, in 0x8000_0000; req1 is op 011, amt 0, in 0x1234_5678, cin 1. Expect cycle 1 grants req0 (0xF800_0000, cout 0) and cycle 2 grants req1 (0x1234_5678, cout 1).
- Back-pressure: rsp_ready[1]=0 with buffer 1 full, req1 valid again. Expect req_ready[1]=0 and rsp_data[1] stable; req0 is still granted every cycle.
- Drain and refill in the same cycle: rsp_valid[0]=1, rsp_ready[0]=1, new req0 op 111, amt 8, in 0x0000_00AB. Expect rsp_valid[0] to stay 1 with data 0xAB00_0000 and cout 1.
- Async reset asserted mid-stream with both buffers full: rsp_valid goes to 00 immediately, before the next clk edge. After release, pointer=RR_INIT; with both requesters valid, the first grant goes to requester 0.
